// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: state, ALU, immediate and opcode encodings shared by the control unit
package multicycle_control_unit_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LINK     = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;

    localparam logic [1:0] ALUOP_ADD = 2'd0;
    localparam logic [1:0] ALUOP_SUB = 2'd1;
    localparam logic [1:0] ALUOP_FN  = 2'd2;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] res_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
    } ctrl_t;

    // f3[2] picks the lt/ltu family, f3[1] picks unsigned, f3[0] inverts the condition
    function automatic logic br_taken(input logic [2:0] f3, input logic zero, input logic lt, input logic ltu);
        return (f3[2] ? (f3[1] ? ltu : lt) : zero) ^ f3[0];
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps aluOp/funct fields to an ALU operation and flags unsupported shift functs
module alu_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_f3,
    input  logic       i_f7,
    input  logic       i_op5,
    output logic [2:0] o_alu_control,
    output logic       o_illegal
);

    logic [2:0] w_fn;

    // funct3 decode; sub only for R-type (op[5]=1) with funct7 bit 5 set
    always_comb begin
        case (i_f3)
            3'b000:  w_fn = (i_op5 && i_f7) ? ALU_SUB : ALU_ADD;
            3'b010:  w_fn = ALU_SLT;
            3'b011:  w_fn = ALU_SLTU;
            3'b100:  w_fn = ALU_XOR;
            3'b110:  w_fn = ALU_OR;
            3'b111:  w_fn = ALU_AND;
            default: w_fn = ALU_ADD;
        endcase
    end

    assign o_illegal     = (i_f3[1:0] == 2'b01);
    assign o_alu_control = (i_alu_op == ALUOP_FN)  ? w_fn :
                           (i_alu_op == ALUOP_SUB) ? ALU_SUB : ALU_ADD;

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a multicycle RV32 datapath
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int BRANCH_ALL = 1,
    parameter int MEM_WAIT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            f3,
    input  logic                  f7,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  memReady,
    output logic                  pcWrite,
    output logic                  adrSrc,
    output logic                  irWrite,
    output logic                  memWrite,
    output logic                  regWrite,
    output logic [1:0]            resSrc,
    output logic [1:0]            aluSrcA,
    output logic [1:0]            aluSrcB,
    output logic [2:0]            immSrc,
    output logic [ALU_CTRL_W-1:0] aluControl,
    output logic                  illegal,
    output logic [3:0]            state
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_illegal;
    logic       w_ready;
    logic       w_fn_ill;
    logic       w_br_ok;
    logic       w_taken;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu;
    ctrl_t      w_ctl;

    assign w_ready = (MEM_WAIT == 0) || memReady;
    assign w_br_ok = (f3[2:1] != 2'b01) && ((BRANCH_ALL != 0) || (f3 == 3'b000));
    assign w_taken = br_taken(f3, zero, lt, ltu);

    alu_decoder u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_f3          (f3),
        .i_f7          (f7),
        .i_op5         (op[5]),
        .o_alu_control (w_alu),
        .o_illegal     (w_fn_ill)
    );

    // next-state: memory states stall on memReady, TRAP is absorbing
    always_comb begin
        w_next = S_TRAP;
        case (r_state)
            S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = w_fn_ill ? S_TRAP : S_EXECR;
                    OP_I:              w_next = w_fn_ill ? S_TRAP : S_EXECI;
                    OP_B:              w_next = w_br_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    default:           w_next = S_TRAP;
                endcase
            S_MEMADR:   w_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL, S_LINK, S_LUI: w_next = S_ALUWB;
            S_JALR:     w_next = S_LINK;
            S_MEMWB, S_ALUWB, S_BRANCH: w_next = S_FETCH;
            default:    w_next = S_TRAP;
        endcase
    end

    // per-state datapath controls; anything not set stays 0
    always_comb begin
        w_ctl    = '0;
        w_alu_op = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_ctl.pc_write  = w_ready;
                w_ctl.ir_write  = w_ready;
                w_ctl.res_src   = 2'b10;
                w_ctl.alu_src_b = 2'b10;
            end
            S_DECODE: begin
                w_ctl.alu_src_a = 2'b01;
                w_ctl.alu_src_b = 2'b01;
                w_ctl.imm_src   = (op == OP_B) ? IMM_B : (op == OP_JAL) ? IMM_J : IMM_I;
            end
            S_MEMADR: begin
                w_ctl.alu_src_a = 2'b10;
                w_ctl.alu_src_b = 2'b01;
                w_ctl.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD:  w_ctl.adr_src = 1'b1;
            S_MEMWB: begin
                w_ctl.res_src   = 2'b01;
                w_ctl.reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                w_ctl.adr_src   = 1'b1;
                w_ctl.mem_write = w_ready;
            end
            S_EXECR: begin
                w_ctl.alu_src_a = 2'b10;
                w_alu_op        = ALUOP_FN;
            end
            S_EXECI: begin
                w_ctl.alu_src_a = 2'b10;
                w_ctl.alu_src_b = 2'b01;
                w_alu_op        = ALUOP_FN;
            end
            S_ALUWB:    w_ctl.reg_write = 1'b1;
            S_BRANCH: begin
                w_ctl.alu_src_a = 2'b10;
                w_ctl.pc_write  = w_taken;
                w_alu_op        = ALUOP_SUB;
            end
            S_JAL: begin
                w_ctl.alu_src_a = 2'b01;
                w_ctl.alu_src_b = 2'b10;
                w_ctl.pc_write  = 1'b1;
            end
            S_JALR: begin
                w_ctl.alu_src_a = 2'b10;
                w_ctl.alu_src_b = 2'b01;
                w_ctl.res_src   = 2'b10;
                w_ctl.pc_write  = 1'b1;
            end
            S_LINK: begin
                w_ctl.alu_src_a = 2'b01;
                w_ctl.alu_src_b = 2'b10;
            end
            S_LUI: begin
                w_ctl.alu_src_a = 2'b11;
                w_ctl.alu_src_b = 2'b01;
                w_ctl.imm_src   = IMM_U;
            end
            default: ;
        endcase
    end

    // state and sticky illegal flag; reset wins over memReady and any state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_TRAP);
        end
    end

    assign pcWrite    = w_ctl.pc_write & ~rst;
    assign irWrite    = w_ctl.ir_write & ~rst;
    assign memWrite   = w_ctl.mem_write & ~rst;
    assign regWrite   = w_ctl.reg_write & ~rst;
    assign adrSrc     = w_ctl.adr_src;
    assign resSrc     = w_ctl.res_src;
    assign aluSrcA    = w_ctl.alu_src_a;
    assign aluSrcB    = w_ctl.alu_src_b;
    assign immSrc     = w_ctl.imm_src;
    assign aluControl = ALU_CTRL_W'(w_alu);
    assign illegal    = r_illegal;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed and random instruction sequences against an instruction-level model
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] f3 = '0;
    logic       f7 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, memReady = 1'b0;

    logic       pcWrite, adrSrc, irWrite, memWrite, regWrite, illegal;
    logic [1:0] resSrc, aluSrcA, aluSrcB;
    logic [2:0] immSrc, aluControl;
    logic [3:0] state;

    logic       pcWrite_b, adrSrc_b, irWrite_b, memWrite_b, regWrite_b, illegal_b;
    logic [1:0] resSrc_b, aluSrcA_b, aluSrcB_b;
    logic [2:0] immSrc_b, aluControl_b;
    logic [3:0] state_b;

    logic [16:0] obs;
    assign obs = {pcWrite, adrSrc, irWrite, memWrite, regWrite, resSrc, aluSrcA, aluSrcB, immSrc, aluControl};

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .zero(zero), .lt(lt), .ltu(ltu),
        .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc), .irWrite(irWrite),
        .memWrite(memWrite), .regWrite(regWrite), .resSrc(resSrc), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .immSrc(immSrc), .aluControl(aluControl), .illegal(illegal), .state(state)
    );

    multicycle_control_unit #(.BRANCH_ALL(0)) dut_b (
        .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .zero(zero), .lt(lt), .ltu(ltu),
        .memReady(memReady), .pcWrite(pcWrite_b), .adrSrc(adrSrc_b), .irWrite(irWrite_b),
        .memWrite(memWrite_b), .regWrite(regWrite_b), .resSrc(resSrc_b), .aluSrcA(aluSrcA_b),
        .aluSrcB(aluSrcB_b), .immSrc(immSrc_b), .aluControl(aluControl_b), .illegal(illegal_b),
        .state(state_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctl;
        logic        w;
    } step_t;

    step_t q[$];
    bit    mr_q[$];

    localparam logic [16:0] STRB = 17'h17000;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // strobes {pcWrite,adrSrc,irWrite,memWrite,regWrite}, resSrc, aluSrcA, aluSrcB, immSrc, aluControl
    function automatic logic [16:0] c(input logic [4:0] s, input logic [1:0] res, input logic [1:0] a,
                                      input logic [1:0] b, input logic [2:0] imm, input logic [2:0] alu);
        return {s, res, a, b, imm, alu};
    endfunction

    function automatic logic [2:0] fn_alu(input logic r, input logic [2:0] fb, input logic f7v);
        case (fb)
            3'b000:  return (r && f7v) ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b011:  return 3'd6;
            3'b100:  return 3'd4;
            3'b110:  return 3'd3;
            3'b111:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] fb, input logic z, input logic l, input logic lu);
        case (fb)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return l;
            3'b101:  return !l;
            3'b110:  return lu;
            3'b111:  return !lu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic put(input logic [3:0] st, input logic [16:0] ctl, input logic w);
        step_t s;
        s.st = st;
        s.ctl = ctl;
        s.w = w;
        q.push_back(s);
    endtask

    // expected state/control sequence of one instruction for the default-parameter unit
    task automatic build(input logic [6:0] o, input logic [2:0] fb, input logic f7v,
                         input logic z, input logic l, input logic lu);
        logic       tr;
        logic       sh;
        logic [2:0] di;
        q.delete();
        tr = 1'b0;
        sh = (fb == 3'b001) || (fb == 3'b101);
        di = (o == 7'b1100011) ? 3'd2 : (o == 7'b1101111) ? 3'd3 : 3'd0;
        put(S_FETCH,  c(5'b10100, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0), 1'b1);
        put(S_DECODE, c(5'b00000, 2'd0, 2'd1, 2'd1, di, 3'd0), 1'b0);
        case (o)
            7'b0000011: begin
                put(S_MEMADR,  c(5'b00000, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0), 1'b0);
                put(S_MEMREAD, c(5'b01000, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), 1'b1);
                put(S_MEMWB,   c(5'b00001, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0), 1'b0);
            end
            7'b0100011: begin
                put(S_MEMADR,   c(5'b00000, 2'd0, 2'd2, 2'd1, 3'd1, 3'd0), 1'b0);
                put(S_MEMWRITE, c(5'b01010, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), 1'b1);
            end
            7'b0110011: begin
                if (sh) tr = 1'b1;
                else begin
                    put(S_EXECR, c(5'b00000, 2'd0, 2'd2, 2'd0, 3'd0, fn_alu(1'b1, fb, f7v)), 1'b0);
                    put(S_ALUWB, c(5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), 1'b0);
                end
            end
            7'b0010011: begin
                if (sh) tr = 1'b1;
                else begin
                    put(S_EXECI, c(5'b00000, 2'd0, 2'd2, 2'd1, 3'd0, fn_alu(1'b0, fb, f7v)), 1'b0);
                    put(S_ALUWB, c(5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), 1'b0);
                end
            end
            7'b1100011: begin
                if (fb[2:1] == 2'b01) tr = 1'b1;
                else put(S_BRANCH, c({taken(fb, z, l, lu), 4'b0000}, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1), 1'b0);
            end
            7'b1101111: begin
                put(S_JAL,   c(5'b10000, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0), 1'b0);
                put(S_ALUWB, c(5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), 1'b0);
            end
            7'b1100111: begin
                put(S_JALR,  c(5'b10000, 2'd2, 2'd2, 2'd1, 3'd0, 3'd0), 1'b0);
                put(S_LINK,  c(5'b00000, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0), 1'b0);
                put(S_ALUWB, c(5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), 1'b0);
            end
            7'b0110111: begin
                put(S_LUI,   c(5'b00000, 2'd0, 2'd3, 2'd1, 3'd4, 3'd0), 1'b0);
                put(S_ALUWB, c(5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), 1'b0);
            end
            default: tr = 1'b1;
        endcase
        if (tr) repeat (3) put(S_TRAP, 17'd0, 1'b0);
    endtask

    task automatic run(input string tag, input logic [6:0] o, input logic [2:0] fb, input logic f7v,
                       input logic z, input logic l, input logic lu, output int n);
        int          i;
        logic [16:0] e;
        build(o, fb, f7v, z, l, lu);
        op = o; f3 = fb; f7 = f7v; zero = z; lt = l; ltu = lu;
        n = 0;
        i = 0;
        while (i < q.size() && n < 64) begin
            memReady = (mr_q.size() != 0) ? mr_q.pop_front() : ($urandom_range(0, 3) != 0);
            #1;
            e = (q[i].w && !memReady) ? (q[i].ctl & ~STRB) : q[i].ctl;
            chk($sformatf("%s c%0d state", tag, n), 32'(state), 32'(q[i].st));
            chk($sformatf("%s c%0d ctl", tag, n), 32'(obs), 32'(e));
            chk($sformatf("%s c%0d illegal", tag, n), 32'(illegal), 32'(q[i].st == S_TRAP));
            @(posedge clk);
            @(negedge clk);
            n++;
            if (!q[i].w || memReady) i++;
        end
        chk($sformatf("%s bound", tag), i, q.size());
    endtask

    task automatic do_reset(input logic mr);
        rst = 1'b1;
        memReady = mr;
        #1;
        chk("rst strobes", {pcWrite, irWrite, memWrite, regWrite}, 4'b0);
        chk("rst strobes_b", {pcWrite_b, irWrite_b, memWrite_b, regWrite_b}, 4'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rst state", state, S_FETCH);
        chk("rst illegal", illegal, 1'b0);
        chk("rst state_b", state_b, S_FETCH);
        chk("rst illegal_b", illegal_b, 1'b0);
        chk("rst strobes held", {pcWrite, irWrite, memWrite, regWrite}, 4'b0);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        logic [6:0] ops[10];
        logic [6:0] o;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111, 7'b0};
        @(negedge clk);
        do_reset(1'b1);

        mr_q = '{1, 1, 1, 1};
        run("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, n);
        chk("add cycles", n, 4);

        mr_q = '{1, 1, 1, 0, 0, 1, 1};
        run("lw_wait", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, n);
        chk("lw cycles", n, 7);

        mr_q = '{1, 1, 1};
        run("bne_taken", 7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, n);
        chk("bne taken cycles", n, 3);
        mr_q = '{1, 1, 1};
        run("bne_not", 7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, n);
        chk("bne not-taken cycles", n, 3);

        mr_q = '{1, 1, 1, 1};
        run("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, n);
        chk("sub cycles", n, 4);
        mr_q = '{1, 1, 1, 1};
        run("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, n);
        chk("sw cycles", n, 4);

        do_reset(1'b1);
        op = 7'b1100011; f3 = 3'b100; memReady = 1'b1;
        for (k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("blt_b0 c%0d state", k), state_b, (k == 0) ? S_FETCH : (k == 1) ? S_DECODE : S_TRAP);
            chk($sformatf("blt_b0 c%0d strobes", k), {pcWrite_b, irWrite_b, memWrite_b, regWrite_b},
                (k == 0) ? 4'b1100 : 4'b0000);
            chk($sformatf("blt_b0 c%0d illegal", k), illegal_b, k >= 2);
            @(posedge clk);
            @(negedge clk);
        end
        do_reset(1'b1);

        mr_q = '{1, 1, 1, 1, 1};
        run("jalr", 7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, n);
        chk("jalr cycles", n, 5);

        op = 7'b0100011; f3 = 3'b010; memReady = 1'b1;
        for (k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("sw_abort c%0d memWrite", k), memWrite, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        memReady = 1'b0;
        #1;
        chk("sw_abort state", state, S_MEMWRITE);
        chk("sw_abort stall memWrite", memWrite, 1'b0);
        @(posedge clk);
        @(negedge clk);
        do_reset(1'b0);
        #1;
        chk("sw_abort after memWrite", memWrite, 1'b0);
        chk("sw_abort after state", state, S_FETCH);
        @(posedge clk);
        @(negedge clk);
        do_reset(1'b1);

        for (int r = 0; r < 80; r++) begin
            k = $urandom_range(0, 9);
            o = (k == 9) ? 7'($urandom) : ops[k];
            run($sformatf("rnd%0d op%0h", r, o), o, 3'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), n);
            if (q[q.size() - 1].st == S_TRAP) do_reset(1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 3: aluControl width; values ≥3; upper bits zero-filled.
REQ-002 SHALL have parameter BRANCH_ALL, default 1: 1 = all six B-type conditions; 0 = BEQ only.
REQ-003 SHALL have parameter MEM_WAIT, default 1: 1 = honour memReady; 0 = treat memReady as constant 1.
REQ-004 SHALL provide these ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- op  in  7  instruction opcode.
- f3  in  3  funct3.
- f7  in  1  funct7 bit 5.
- zero, lt, ltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- memReady  in  1  memory access completes this cycle.
- pcWrite, adrSrc, irWrite, memWrite, regWrite  out  1 each  datapath enables/selects.
- resSrc, aluSrcA, aluSrcB  out  2 each  mux selects.
- immSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- aluControl  out  ALU_CTRL_W  ALU operation.
- illegal  out  1  sticky unsupported-instruction flag.
- state  out  4  current FSM state, for debug.

Function
REQ-005 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, LUI, TRAP.
REQ-006 Transitions SHALL be:
- FETCH→DECODE.
- DECODE→ load/store MEMADR; R EXECR; I-ALU EXECI; B BRANCH; JAL JAL; JALR JALR; LUI LUI; else TRAP.
- MEMADR→ MEMREAD (load) or MEMWRITE (store).
- MEMREAD→MEMWB.
- EXECR, EXECI, JAL, LINK, LUI → ALUWB.
- JALR→LINK.
- MEMWB, MEMWRITE, ALUWB, BRANCH → FETCH.
- TRAP→TRAP.
REQ-007 With MEM_WAIT=1, FETCH, MEMREAD and MEMWRITE SHALL hold until memReady=1; their write strobes assert only in the memReady=1 cycle.
REQ-008 FETCH SHALL drive adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, add, resSrc=10, pcWrite=1.
REQ-009 DECODE SHALL drive aluSrcA=01, aluSrcB=01, add, immSrc=B for B-type and J for JAL; no write strobes.
REQ-010 MEMADR SHALL compute rs1+imm (aluSrcA=10, aluSrcB=01), with immSrc=S for stores and I otherwise.
REQ-011 MEMREAD SHALL drive adrSrc=1, resSrc=00.
REQ-012 MEMWB SHALL drive resSrc=01, regWrite=1.
REQ-013 MEMWRITE SHALL drive adrSrc=1, memWrite=1.
REQ-014 ALUWB SHALL drive resSrc=00, regWrite=1.
REQ-015 EXECR/EXECI SHALL use funct-decoded ALU ops:
- 000 add (sub when R-type and f7=1), 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
- Shift funct3 values SHALL route to TRAP.
- ALU codes: add 000, sub 001, and 010, or 011, xor 100, slt 101, sltu 110.
REQ-016 BRANCH SHALL drive sub, aluSrcA=10, aluSrcB=00, resSrc=00, with pcWrite=taken.
REQ-017 taken SHALL decode as: beq zero; bne !zero; blt lt; bge !lt; bltu ltu; bgeu !ltu.
REQ-018 With BRANCH_ALL=0, any funct3≠000 SHALL go DECODE→TRAP.
REQ-019 JAL SHALL drive aluSrcA=01, aluSrcB=10, resSrc=00, pcWrite=1.
REQ-020 JALR SHALL drive aluSrcA=10, aluSrcB=01, immSrc=I, add, resSrc=10, pcWrite=1.
REQ-021 LINK SHALL drive aluSrcA=01, aluSrcB=10, add.
REQ-022 LUI SHALL drive aluSrcA=11, aluSrcB=01, immSrc=U, add.
REQ-023 TRAP SHALL hold all write strobes at 0; illegal SHALL set on TRAP entry and stay set until reset.
REQ-024 Latency in cycles, with memReady=1, SHALL be: branch 3; R/I/JAL/LUI/store 4; JALR/load 5.
REQ-025 Unlisted outputs SHALL be 0 in each state.

Reset
REQ-026 While rst=1, all write strobes (pcWrite, irWrite, memWrite, regWrite) SHALL be forced to 0.
REQ-027 While rst=1, illegal SHALL clear at the next edge.
REQ-028 rst=1 SHALL override memReady and any state; the FSM SHALL be in FETCH after the first edge with rst=1.
REQ-029 rst asserted mid-instruction SHALL abort it with no further strobes.

Structure
REQ-030 A shared package SHALL hold the state encodings, ALU operation codes, immSrc codes and opcode constants.
REQ-031 The block SHALL instantiate one combinational sub-module, alu_decoder, taking aluOp, f3, f7 and op[5] and producing aluControl and funct-illegal.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- add x3,x1,x2 (op 0110011, f3 000, f7 0), memReady=1 → FETCH,DECODE,EXECR,ALUWB; regWrite=1 in cycle 4 only; aluControl=000.
- lw, memReady low 2 cycles in MEMREAD → 7 cycles total; regWrite=1 once in MEMWB.
- bne with zero=0 → pcWrite=1 in BRANCH; repeat with zero=1 → pcWrite=0; back to FETCH after 3 cycles.
- BRANCH_ALL=0, blt → TRAP; illegal=1; no strobes thereafter; rst=1 → FETCH, illegal=0.
- jalr → JALR pcWrite=1, resSrc=10; LINK; ALUWB regWrite=1; 5 cycles.
- rst asserted in MEMWRITE while memReady=0 → memWrite never asserted; state=FETCH after the edge.
